// File: rtl/matrix_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_reader_pkg
//  Description : Shared types and constants for the matrix read path. The
//                column geometry constants are the ones the display path
//                uses, so a captured image can be fed back to the display.
//  Revision    : 1.0 - initial release
// ============================================================================
package matrix_reader_pkg;

   localparam int c_COLUNE_SIZE   = 7;
   localparam int c_TOTAL_COLUNES = 5;
   localparam int c_DATA_WIDTH    = c_COLUNE_SIZE * c_TOTAL_COLUNES;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_PUBLISH = 2'd2
   } state_e;

   // Bit offset of column 'col' in the column-major image packing.
   function automatic int col_offset(input int col, input int size);
      return col * size;
   endfunction

endpackage
`default_nettype wire

// File: rtl/matrix_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_reader_if
//  Description : Sense/drive and image bus of the matrix reader. The master
//                side drives enable and the sense lines; the slave (reader)
//                drives the column activator and the captured image.
//  Revision    : 1.0 - initial release
// ============================================================================
interface matrix_reader_if
   import matrix_reader_pkg::*;
#(
   parameter int COLUNE_SIZE   = c_COLUNE_SIZE,
   parameter int TOTAL_COLUNES = c_TOTAL_COLUNES,
   parameter int DATA_WIDTH    = c_DATA_WIDTH
);

   logic                     enable;
   logic [COLUNE_SIZE-1:0]   colune_sense;
   logic [TOTAL_COLUNES-1:0] colune_activator;
   logic [DATA_WIDTH-1:0]    image;
   logic                     frame_valid;
   logic                     frame_changed;

   modport master (
      output enable,
      output colune_sense,
      input  colune_activator,
      input  image,
      input  frame_valid,
      input  frame_changed
   );

   modport slave (
      input  enable,
      input  colune_sense,
      output colune_activator,
      output image,
      output frame_valid,
      output frame_changed
   );

endinterface
`default_nettype wire

// File: rtl/matrix_reader_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_reader_column_sequencer
//  Description : Column index and settle counter for the matrix scan. Drives
//                the registered one-hot column activator and flags the
//                sampling cycle and the last column to the controlling FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_reader_column_sequencer #(
   parameter int TOTAL_COLUNES = 5,
   parameter int SETTLE_CYCLES = 4,
   parameter int IDX_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1,
   parameter int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
   input  wire logic                     clk,
   input  wire logic                     reset,
   input  wire logic                     start_i,          // begin a scan at column 0
   input  wire logic                     run_i,            // keep scanning this cycle
   output logic      [IDX_W-1:0]         col_idx_o,
   output logic                          sample_strobe_o,  // sample the sense lines at this edge
   output logic                          last_column_o,
   output logic      [TOTAL_COLUNES-1:0] activator_o
);

   localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(TOTAL_COLUNES - 1);

   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [IDX_W-1:0]         idx_q, idx_d;
   logic [TOTAL_COLUNES-1:0] act_q, act_d;
   logic                     w_cnt_done;

   assign w_cnt_done      = (cnt_q == c_CNT_LAST);
   assign sample_strobe_o = run_i & w_cnt_done;
   assign last_column_o   = (idx_q == c_IDX_LAST);
   assign col_idx_o       = idx_q;
   assign activator_o     = act_q;

   // Next index/count/activator; anything other than start or run blanks the
   // drive and parks the sequencer at column 0.
   always_comb begin
      cnt_d = '0;
      idx_d = '0;
      act_d = '0;
      if (start_i) begin
         act_d = TOTAL_COLUNES'(1);
      end else if (run_i) begin
         if (w_cnt_done) begin
            if (!last_column_o) begin
               idx_d = idx_q + IDX_W'(1);
               act_d = act_q << 1;
            end else begin
               // Last column sampled: hold index, blank for the publish cycle.
               idx_d = idx_q;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
            act_d = act_q;
         end
      end
   end

   // Sequencer registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         idx_q <= '0;
         act_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         act_q <= act_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/matrix_reader.sv
`default_nettype none
// ============================================================================
//  Module      : matrix_reader
//  Description : Column-scanned matrix reader. Drives one column at a time,
//                samples the row sense lines after a settle interval and
//                publishes a column-major image once per frame, flagging
//                frames that differ from the previous one.
//                DATA_WIDTH must equal COLUNE_SIZE*TOTAL_COLUNES.
//  Revision    : 1.0 - initial release
// ============================================================================
module matrix_reader
   import matrix_reader_pkg::*;
#(
   parameter int DATA_WIDTH    = c_DATA_WIDTH,
   parameter int COLUNE_SIZE   = c_COLUNE_SIZE,
   parameter int TOTAL_COLUNES = c_TOTAL_COLUNES,
   parameter int SETTLE_CYCLES = 4
) (
   input  wire logic       clk,
   input  wire logic       reset,
   matrix_reader_if.slave  bus
);

   localparam int IDX_W = (TOTAL_COLUNES > 1) ? $clog2(TOTAL_COLUNES) : 1;

   localparam logic [1:0] c_IDLE    = ST_IDLE;
   localparam logic [1:0] c_DRIVE   = ST_DRIVE;
   localparam logic [1:0] c_PUBLISH = ST_PUBLISH;

   logic [1:0]               state_q, state_d;
   logic                     w_start, w_run, w_publish;
   logic                     w_strobe, w_last;
   logic [IDX_W-1:0]         w_col_idx;
   logic [TOTAL_COLUNES-1:0] w_activator;
   logic [TOTAL_COLUNES-1:0] w_col_sel;

   logic [DATA_WIDTH-1:0]    capture_q;
   logic [DATA_WIDTH-1:0]    image_q;
   logic                     frame_valid_q;
   logic                     frame_changed_q;

   matrix_reader_column_sequencer #(
      .TOTAL_COLUNES (TOTAL_COLUNES),
      .SETTLE_CYCLES (SETTLE_CYCLES)
   ) u_seq (
      .clk             (clk),
      .reset           (reset),
      .start_i         (w_start),
      .run_i           (w_run),
      .col_idx_o       (w_col_idx),
      .sample_strobe_o (w_strobe),
      .last_column_o   (w_last),
      .activator_o     (w_activator)
   );

   // Scanning continues only while enable is still high; a low enable in
   // DRIVE aborts the frame at this edge without sampling.
   assign w_run = (state_q == c_DRIVE) && bus.enable;

   // Scan FSM: IDLE -> DRIVE (all columns) -> PUBLISH -> DRIVE/IDLE.
   always_comb begin
      state_d   = state_q;
      w_start   = 1'b0;
      w_publish = 1'b0;
      case (state_q)
         c_IDLE: begin
            if (bus.enable) begin
               state_d = c_DRIVE;
               w_start = 1'b1;
            end
         end
         c_DRIVE: begin
            if (!bus.enable) begin
               state_d = c_IDLE;
            end else if (w_strobe && w_last) begin
               state_d = c_PUBLISH;
            end
         end
         c_PUBLISH: begin
            w_publish = 1'b1;
            if (bus.enable) begin
               state_d = c_DRIVE;
               w_start = 1'b1;
            end else begin
               state_d = c_IDLE;
            end
         end
         default: state_d = c_IDLE;
      endcase
   end

   // One write-select per column slice of the capture buffer.
   for (genvar k = 0; k < TOTAL_COLUNES; k++) begin : g_col_sel
      assign w_col_sel[k] = w_strobe && (w_col_idx == IDX_W'(k));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= c_IDLE;
      else       state_q <= state_d;
   end

   // Capture buffer: a partial frame left by an abort is never cleared since
   // every slice is rewritten before the next publish.
   always_ff @(posedge clk) begin
      if (reset) begin
         capture_q <= '0;
      end else begin
         for (int k = 0; k < TOTAL_COLUNES; k++) begin
            if (w_col_sel[k]) begin
               capture_q[col_offset(k, COLUNE_SIZE) +: COLUNE_SIZE] <= bus.colune_sense;
            end
         end
      end
   end

   // Published image and the per-frame pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         image_q         <= '0;
         frame_valid_q   <= 1'b0;
         frame_changed_q <= 1'b0;
      end else begin
         frame_valid_q   <= w_publish;
         frame_changed_q <= w_publish && (capture_q != image_q);
         if (w_publish) image_q <= capture_q;
      end
   end

   assign bus.colune_activator = w_activator;
   assign bus.image            = image_q;
   assign bus.frame_valid      = frame_valid_q;
   assign bus.frame_changed    = frame_changed_q;

endmodule
`default_nettype wire

// File: tb/tb_matrix_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_matrix_reader
//  Description : Directed self-checking bench for matrix_reader. A second
//                instance runs with a single settle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_reader;

   logic clk = 1'b0;
   logic reset;
   logic rst1;

   always #5 clk = ~clk;

   matrix_reader_if bus_a ();
   matrix_reader_if bus_b ();

   matrix_reader #(
      .DATA_WIDTH (35), .COLUNE_SIZE (7), .TOTAL_COLUNES (5), .SETTLE_CYCLES (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   matrix_reader #(
      .DATA_WIDTH (35), .COLUNE_SIZE (7), .TOTAL_COLUNES (5), .SETTLE_CYCLES (1)
   ) dut_s1 (
      .clk   (clk),
      .reset (rst1),
      .bus   (bus_b)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;

   logic [6:0] pat [5];
   logic [6:0] tog [4];
   logic [34:0] img_prev;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Sense value the bench presents for whichever column is being driven.
   function automatic logic [6:0] sense_for(input logic [4:0] act);
      logic [6:0] v;
      v = 7'h00;
      for (int i = 0; i < 5; i++) if (act == 5'(1 << i)) v = pat[i];
      return v;
   endfunction

   // Runs the 21 edges following a column-0 start; the activator follows
   // col = k/4 for k < 20, blanks at k = 20 and restarts at k = 21 if enabled.
   task automatic run_frame(input string tag, input bit settle_mode, input bit drop_in_publish);
      logic [4:0] exp_a;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k < 20)       exp_a = 5'(1 << (k / 4));
         else if (k == 20) exp_a = 5'd0;
         else              exp_a = drop_in_publish ? 5'd0 : 5'd1;
         chk({tag, "_act"}, 64'(bus_a.colune_activator), 64'(exp_a));
         chk({tag, "_fv"},  64'(bus_a.frame_valid),      64'(k == 21));
         if (settle_mode && k <= 3) bus_a.colune_sense = tog[k];
         else                       bus_a.colune_sense = sense_for(bus_a.colune_activator);
         if (drop_in_publish && k == 20) bus_a.enable = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      tog[0] = 7'h2A; tog[1] = 7'h7F; tog[2] = 7'h00; tog[3] = 7'h55;

      // ---- Reset held with enable high --------------------------------
      reset = 1'b1; rst1 = 1'b1;
      bus_a.enable = 1'b1; bus_a.colune_sense = 7'h00;
      bus_b.enable = 1'b0; bus_b.colune_sense = 7'h00;
      tick(); tick();
      chk("rst_act",   64'(bus_a.colune_activator), 64'(0));
      chk("rst_image", 64'(bus_a.image),            64'(0));
      chk("rst_fv",    64'(bus_a.frame_valid),      64'(0));
      chk("rst_fc",    64'(bus_a.frame_changed),    64'(0));

      // ---- Frame 1: walking-one pattern -------------------------------
      pat[0] = 7'h01; pat[1] = 7'h02; pat[2] = 7'h04; pat[3] = 7'h08; pat[4] = 7'h10;
      reset = 1'b0;
      tick();
      chk("start_act", 64'(bus_a.colune_activator), 64'(5'b00001));
      bus_a.colune_sense = sense_for(bus_a.colune_activator);
      run_frame("f1", 1'b0, 1'b0);
      // 01 | 02<<7 | 04<<14 | 08<<21 | 10<<28
      chk("f1_image", 64'(bus_a.image),         64'(35'h1_0101_0101));
      chk("f1_fc",    64'(bus_a.frame_changed), 64'(1));

      // ---- Frame 2: same input, no change ------------------------------
      run_frame("f2", 1'b0, 1'b0);
      chk("f2_image", 64'(bus_a.image),         64'(35'h1_0101_0101));
      chk("f2_fc",    64'(bus_a.frame_changed), 64'(0));
      img_prev = 35'h1_0101_0101;

      // ---- Abort during column 2 of an all-ones frame ------------------
      for (int i = 0; i < 5; i++) pat[i] = 7'h7F;
      bus_a.colune_sense = sense_for(bus_a.colune_activator);
      for (int k = 1; k <= 9; k++) begin
         tick();
         chk("ab_act", 64'(bus_a.colune_activator), 64'(5'(1 << (k / 4))));
         chk("ab_fv",  64'(bus_a.frame_valid),      64'(0));
         bus_a.colune_sense = sense_for(bus_a.colune_activator);
      end
      bus_a.enable = 1'b0;
      tick();
      chk("ab_act_off", 64'(bus_a.colune_activator), 64'(0));
      chk("ab_fc",      64'(bus_a.frame_changed),    64'(0));
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         tick();
         if (bus_a.frame_valid || bus_a.colune_activator != 5'd0) seen++;
      end
      chk("ab_quiet", 64'(seen),        64'(0));
      chk("ab_image", 64'(bus_a.image), 64'(img_prev));

      // ---- Re-enable: full frame, enable dropped in PUBLISH ------------
      bus_a.enable = 1'b1;
      tick();
      chk("re_act", 64'(bus_a.colune_activator), 64'(5'b00001));
      bus_a.colune_sense = sense_for(bus_a.colune_activator);
      run_frame("f3", 1'b0, 1'b1);
      chk("f3_image", 64'(bus_a.image),         64'({5{7'h7F}}));
      chk("f3_fc",    64'(bus_a.frame_changed), 64'(1));
      tick();
      chk("f3_fv_pulse", 64'(bus_a.frame_valid),      64'(0));
      chk("f3_fc_pulse", 64'(bus_a.frame_changed),    64'(0));
      chk("f3_idle_act", 64'(bus_a.colune_activator), 64'(0));

      // ---- Settle window: only the last settle cycle is captured -------
      for (int i = 0; i < 5; i++) pat[i] = 7'h00;
      bus_a.enable = 1'b1;
      tick();
      chk("st_act", 64'(bus_a.colune_activator), 64'(5'b00001));
      bus_a.colune_sense = tog[0];
      run_frame("fs", 1'b1, 1'b0);
      chk("st_image", 64'(bus_a.image),         64'(35'h55));
      chk("st_fc",    64'(bus_a.frame_changed), 64'(1));

      // ---- Reset on the PUBLISH cycle, enable still high ---------------
      for (int k = 1; k <= 20; k++) begin
         tick();
         bus_a.colune_sense = sense_for(bus_a.colune_activator);
      end
      chk("rp_pub_act", 64'(bus_a.colune_activator), 64'(0));
      reset = 1'b1;
      tick();
      chk("rp_image", 64'(bus_a.image),            64'(0));
      chk("rp_fv",    64'(bus_a.frame_valid),      64'(0));
      chk("rp_fc",    64'(bus_a.frame_changed),    64'(0));
      chk("rp_act",   64'(bus_a.colune_activator), 64'(0));
      reset = 1'b0;
      tick();
      chk("rp_restart", 64'(bus_a.colune_activator), 64'(5'b00001));

      // ---- Single settle cycle: frame period of 6 ----------------------
      rst1 = 1'b0;
      bus_b.enable = 1'b1;
      bus_b.colune_sense = 7'h33;
      tick();
      chk("s1_start", 64'(bus_b.colune_activator), 64'(5'b00001));
      for (int k = 1; k <= 6; k++) begin
         tick();
         chk("s1_act", 64'(bus_b.colune_activator),
             64'((k < 5) ? 5'(1 << k) : ((k == 5) ? 5'd0 : 5'd1)));
         chk("s1_fv",  64'(bus_b.frame_valid), 64'(k == 6));
      end
      chk("s1_image", 64'(bus_b.image),         64'({5{7'h33}}));
      chk("s1_fc",    64'(bus_b.frame_changed), 64'(1));

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
